// File: rtl/alu_issue_if.sv
// =============================================================================
// alu_issue_if : issue-side and ALU-side handshake bundle for alu_issue
// Rev 1.0
// =============================================================================
`default_nettype none

interface alu_issue_if #(
    parameter int D_WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [D_WIDTH-1:0] rs_data;
    logic [D_WIDTH-1:0] rt_data;
    logic               out_valid;
    logic               out_ready;
    logic               alu_enable;
    logic [2:0]         op_code;
    logic [D_WIDTH-1:0] operand1;
    logic [D_WIDTH-1:0] operand2;
    logic [4:0]         dest_reg;
    logic               illegal_op;

    modport slave (
        input  in_valid, instr, rs_data, rt_data, out_ready,
        output in_ready, out_valid, alu_enable, op_code, operand1, operand2,
               dest_reg, illegal_op
    );

    modport master (
        output in_valid, instr, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, alu_enable, op_code, operand1, operand2,
               dest_reg, illegal_op
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
// =============================================================================
// alu_issue : decodes MIPS ALU instructions and queues them in a 2-entry skid buffer
// Rev 1.0
// =============================================================================
`default_nettype none

module alu_issue #(
    parameter int D_WIDTH    = 32,
    parameter int SHAMT_ZEXT = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic flush,
    alu_issue_if.slave bus
);

    typedef struct packed {
        logic [2:0]         op;
        logic [D_WIDTH-1:0] op1;
        logic [D_WIDTH-1:0] op2;
        logic [4:0]         dest;
    } entry_t;

    localparam logic [1:0] c_depth = 2'd2;

    logic [1:0]         r_count;
    entry_t             r_head;
    entry_t             r_tail;
    logic               r_illegal;

    entry_t             w_new;
    logic               w_legal;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_shamt_fill;
    logic               w_unused_rs;
    logic [5:0]         w_opcode;
    logic [5:0]         w_funct;
    logic [4:0]         w_rt;
    logic [4:0]         w_rd;
    logic [4:0]         w_shamt;
    logic [D_WIDTH-1:0] w_shamt_ext;
    logic [D_WIDTH-1:0] w_imm_ext;

    assign w_opcode     = bus.instr[31:26];
    assign w_rt         = bus.instr[20:16];
    assign w_rd         = bus.instr[15:11];
    assign w_shamt      = bus.instr[10:6];
    assign w_funct      = bus.instr[5:0];
    assign w_unused_rs  = ^bus.instr[25:21];
    assign w_shamt_fill = (SHAMT_ZEXT != 0) ? 1'b0 : w_shamt[4];
    assign w_shamt_ext  = {{(D_WIDTH-5){w_shamt_fill}}, w_shamt};
    assign w_imm_ext    = {{(D_WIDTH-16){bus.instr[15]}}, bus.instr[15:0]};

    always_comb begin
        w_legal  = 1'b0;
        w_new    = '{op: 3'd0, op1: bus.rs_data, op2: bus.rt_data, dest: w_rd};
        case (w_opcode)
            6'h00: begin
                case (w_funct)
                    6'h20: begin w_legal = 1'b1; w_new.op = 3'd0; end
                    6'h22: begin w_legal = 1'b1; w_new.op = 3'd1; end
                    6'h18: begin w_legal = 1'b1; w_new.op = 3'd2; end
                    6'h1A: begin w_legal = 1'b1; w_new.op = 3'd3; end
                    6'h00: begin
                        w_legal   = 1'b1;
                        w_new.op  = 3'd4;
                        w_new.op1 = bus.rt_data;
                        w_new.op2 = w_shamt_ext;
                    end
                    6'h02: begin
                        w_legal   = 1'b1;
                        w_new.op  = 3'd5;
                        w_new.op1 = bus.rt_data;
                        w_new.op2 = w_shamt_ext;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            6'h08: begin
                w_legal    = 1'b1;
                w_new.op2  = w_imm_ext;
                w_new.dest = w_rt;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign bus.in_ready   = (r_count < c_depth) & rst_n;
    assign w_accept       = bus.in_valid & bus.in_ready;
    assign w_push         = w_accept & w_legal;
    assign w_pop          = (r_count != 2'd0) & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= 2'd0;
            r_head    <= '0;
            r_tail    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept & ~w_legal & ~flush;
            if (flush) begin
                r_count <= 2'd0;
            end else begin
                // Head register is the output stage; tail only fills behind a stalled head.
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_count == 2'd0) r_head <= w_new;
                        else                 r_tail <= w_new;
                        r_count <= r_count + 2'd1;
                    end
                    2'b01: begin
                        if (r_count == c_depth) r_head <= r_tail;
                        r_count <= r_count - 2'd1;
                    end
                    2'b11: begin
                        if (r_count == 2'd1) begin
                            r_head <= w_new;
                        end else begin
                            r_head <= r_tail;
                            r_tail <= w_new;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.alu_enable = bus.out_valid;
    assign bus.op_code    = r_head.op;
    assign bus.operand1   = r_head.op1;
    assign bus.operand2   = r_head.op2;
    assign bus.dest_reg   = r_head.dest;
    assign bus.illegal_op = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// =============================================================================
// tb_alu_issue : scoreboard bench for alu_issue (directed + random stimulus)
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_alu_issue;

    typedef struct {
        int unsigned op;
        int unsigned op1;
        int unsigned op2;
        int unsigned dest;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;
    int   model_cnt;
    bit   exp_ill;
    bit   started;
    exp_t sb_q[$];

    alu_issue_if #(.D_WIDTH(32)) bus ();

    alu_issue #(.D_WIDTH(32), .SHAMT_ZEXT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        rtype = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(input int opc, input int rs, input int rt,
                                          input int imm);
        itype = {6'(opc), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic void model(input logic [31:0] ins, input int unsigned rs,
                                  input int unsigned rt, output bit legal, output exp_t e);
        int unsigned opc;
        int unsigned fn;
        int          imm;
        opc   = ins >> 26;
        fn    = ins & 32'h3F;
        imm   = int'($signed(ins[15:0]));
        legal = 1'b1;
        e.op1 = rs;
        e.op2 = rt;
        e.dest = (ins >> 11) & 32'h1F;
        e.op  = 0;
        if (opc == 0 && fn == 32'h20)      e.op = 0;
        else if (opc == 0 && fn == 32'h22) e.op = 1;
        else if (opc == 0 && fn == 32'h18) e.op = 2;
        else if (opc == 0 && fn == 32'h1A) e.op = 3;
        else if (opc == 0 && (fn == 0 || fn == 2)) begin
            e.op  = (fn == 0) ? 4 : 5;
            e.op1 = rt;
            e.op2 = (ins >> 6) & 32'h1F;
        end else if (opc == 8) begin
            e.op2  = imm;
            e.dest = (ins >> 16) & 32'h1F;
        end else legal = 1'b0;
    endfunction

    // One clock of stimulus; the model count and illegal expectation advance with it.
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input bit ordy, input bit fl, input bit rn);
        bit   acc;
        bit   legal;
        bit   ill;
        bit   pop;
        int   ncnt;
        exp_t e;
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        bus.out_ready = ordy;
        flush         = fl;
        rst_n         = rn;
        @(negedge clk);
        chk("in_ready", 32'(bus.in_ready), 32'(model_cnt < 2 && rn));
        chk("out_valid", 32'(bus.out_valid), 32'(model_cnt != 0));
        chk("alu_enable", 32'(bus.alu_enable), 32'(model_cnt != 0));
        acc = v && model_cnt < 2 && rn;
        model(ins, rs, rt, legal, e);
        pop = (model_cnt != 0) && ordy;
        ill = 1'b0;
        if (!rn || fl) begin
            sb_q.delete();
            ncnt = 0;
        end else begin
            if (acc && legal) sb_q.push_back(e);
            ncnt = model_cnt + int'(acc && legal) - int'(pop);
            ill  = acc && !legal;
        end
        @(posedge clk);
        #1;
        model_cnt = ncnt;
        exp_ill   = ill;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
            if (rst_n && !flush && bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected act=out_valid exp=no_entry t=%0t", $time);
                end else begin
                    chk("op_code", 32'(bus.op_code), sb_q[0].op);
                    chk("operand1", bus.operand1, sb_q[0].op1);
                    chk("operand2", bus.operand2, sb_q[0].op2);
                    chk("dest_reg", 32'(bus.dest_reg), sb_q[0].dest);
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_zero();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_alu_enable", 32'(bus.alu_enable), 32'h0);
        chk("rst_op_code", 32'(bus.op_code), 32'h0);
        chk("rst_operand1", bus.operand1, 32'h0);
        chk("rst_operand2", bus.operand2, 32'h0);
        chk("rst_dest_reg", 32'(bus.dest_reg), 32'h0);
        chk("rst_illegal_op", 32'(bus.illegal_op), 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: rand_instr = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 'h20);
            1: rand_instr = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 'h22);
            2: rand_instr = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 'h18);
            3: rand_instr = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 'h1A);
            4: rand_instr = rtype(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 'h00);
            5: rand_instr = rtype(0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 'h02);
            6: rand_instr = itype('h08, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
            default: begin
                if ($urandom_range(0, 1) == 1)
                    rand_instr = itype('h23 + $urandom_range(0, 8), $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
                else
                    rand_instr = rtype($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 'h21);
            end
        endcase
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        model_cnt = 0;
        exp_ill   = 1'b0;
        started   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.rs_data   = 32'h0;
        bus.rt_data   = 32'h0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk);
        #1;
        started = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_reset_zero();

        // Single addi with negative immediate.
        cycle(1'b1, 32'h2128FFFC, 32'd10, 32'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Shifts, including the largest shift amount.
        cycle(1'b1, rtype(0, 5, 3, 4, 'h00), 32'hDEAD, 32'h1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, rtype(0, 5, 3, 31, 'h02), 32'hDEAD, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure fills the buffer, then drains in order.
        cycle(1'b1, rtype(1, 2, 7, 0, 'h20), 32'd11, 32'd22, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rtype(3, 4, 9, 0, 'h22), 32'd33, 32'd44, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rtype(3, 4, 9, 0, 'h18), 32'd55, 32'd66, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Streaming mult/div/add with out_ready held high.
        cycle(1'b1, rtype(1, 2, 10, 0, 'h18), 32'd5, 32'd6, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, rtype(1, 2, 11, 0, 'h1A), 32'd7, 32'd8, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, rtype(1, 2, 12, 0, 'h20), 32'd9, 32'd1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Illegal lw.
        cycle(1'b1, 32'h8C00_0000, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full, with a simultaneous legal and then illegal accept attempt.
        cycle(1'b1, rtype(1, 2, 7, 0, 'h20), 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rtype(1, 2, 8, 0, 'h22), 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rtype(1, 2, 9, 0, 'h20), 32'd5, 32'd6, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h8C00_0000, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-operation.
        cycle(1'b1, rtype(1, 2, 7, 0, 'h20), 32'hAAAA, 32'hBBBB, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rtype(1, 2, 8, 0, 'h22), 32'hCCCC, 32'hDDDD, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rtype(1, 2, 9, 0, 'h20), 32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        chk_reset_zero();
        idle(1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 149) != 0));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Execute-stage issue unit sitting directly upstream of the ALU. It accepts decoded-stage instructions with their register-file operands, maps opcode/funct onto the ALU's 3-bit op_code, and selects operand2 from the rt value, the sign-extended immediate or shamt. It holds issued operations in a 2-entry in-order skid buffer with valid/ready handshakes on both sides. The ALU is driven from the buffer head, and dest_reg travels alongside for writeback.

Parameters:
D_WIDTH, 32, datapath width of operands and ALU result.
SHAMT_ZEXT, 1, shamt zero-extended to D_WIDTH for sll/srl (fixed at 1; present for lint visibility).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
flush  input  1  synchronous; discards all buffered and in-flight entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  unit can accept this cycle
instr  input  32  MIPS instruction word
rs_data  input  D_WIDTH  register value for rs
rt_data  input  D_WIDTH  register value for rt
out_valid  output  1  head entry valid
out_ready  input  1  downstream (ALU/EX-MEM) consumes head
alu_enable  output  1  equals out_valid; drives ALU enable
op_code  output  3  ALU op of head entry
operand1  output  D_WIDTH  ALU operand1
operand2  output  D_WIDTH  ALU operand2
dest_reg  output  5  writeback register index
illegal_op  output  1  one-cycle pulse for an unsupported instruction

Behaviour:
- Reset (rst_n=0 at a clock edge): buffer emptied.
  - out_valid=0, alu_enable=0, op_code=0, operand1=0, operand2=0, dest_reg=0, illegal_op=0.
  - in_ready forced 0 while rst_n=0; it is 1 in the first cycle after release.
- Accept: occurs when in_valid & in_ready at a clock edge. in_ready = (count<2) & rst_n. It is combinational from the registered count only and never depends on out_ready.
- Decode (opcode=instr[31:26], funct=instr[5:0], rs/rt/rd/shamt standard fields):
  - R-type (opcode 0):
    - funct 0x20 add -> op 0; op1=rs_data, op2=rt_data, dest=rd.
    - funct 0x22 sub -> op 1; op1=rs_data, op2=rt_data, dest=rd.
    - funct 0x18 mult -> op 2; op1=rs_data, op2=rt_data, dest=rd.
    - funct 0x1A div -> op 3; op1=rs_data, op2=rt_data, dest=rd.
    - funct 0x00 sll -> op 4; op1=rt_data, op2=zero-extended shamt, dest=rd.
    - funct 0x02 srl -> op 5; op1=rt_data, op2=zero-extended shamt, dest=rd.
  - addi (opcode 0x08) -> op 0; op1=rs_data, op2=sign-extended instr[15:0], dest=rt.
  - Anything else is illegal: accepted (consumes the handshake) but not enqueued. illegal_op pulses high for exactly the cycle after acceptance.
- Buffer: 2-entry FIFO, strictly in order. Each entry holds {op_code, operand1, operand2, dest_reg}.
  - Outputs are registered copies of the head entry.
  - Latency: legal instruction accepted at edge N -> out_valid=1 in the cycle following N when the buffer was empty.
  - Pop: occurs when out_valid & out_ready at an edge. The next entry (if any) appears in the following cycle.
  - Push and pop at the same edge: count is unchanged and order is preserved. This is allowed at count=2 only if in_ready was 1; it never is at count=2.
  - Full (count=2): in_ready=0, and the head is held stable until popped.
  - Empty: out_valid=0. op_code/operands hold their last values; downstream must qualify with out_valid.
  - Output fields are stable while out_valid=1 and out_ready=0.
- flush=1 at an edge:
  - count becomes 0, out_valid=0, and any simultaneous accept is dropped.
  - illegal_op for an instruction accepted that same edge is suppressed.
  - flush has priority over push and pop; rst_n has priority over flush.
- Width rules:
  - Sign extension replicates instr[15] to D_WIDTH.
  - shamt occupies bits [4:0], with upper bits zero.
  - No arithmetic is performed here.

Test Plan:
- Reset then single addi: instr=0x2128FFFC (addi t0? rs=9, rt=8, imm=-4), rs_data=10, out_ready=1 -> next cycle out_valid=1, op_code=0, operand1=10, operand2=0xFFFFFFFC, dest_reg=8; out_valid=0 the cycle after.
- sll: instr with rt=5, rd=3, shamt=4, funct 0, rt_data=0x1 -> op_code=4, operand1=1, operand2=4, dest_reg=3. srl with shamt=31 -> op_code=5, operand2=31.
- Backpressure: out_ready=0, issue add then sub -> in_ready=0 after the second accept; head stays op_code=0 with stable operands. Raise out_ready -> sub appears the next cycle with op_code=1, and in_ready returns to 1.
- Streaming: out_ready=1, in_valid=1 every cycle with mult/div/add sequence -> one output per cycle in order (2, 3, 0), in_ready constantly 1.
- Illegal: opcode 0x23 (lw) accepted -> illegal_op=1 for exactly one cycle, out_valid stays 0, and no buffer entry is created.
- Flush/reset mid-operation: buffer full with out_ready=0, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and no entry emerges. Repeat with rst_n=0 -> all outputs return to 0.
